// File: rtl/fp_mult_pipe.sv
// Pipelined floating-point multiplier: unpack/multiply, normalise, round/except.
// A single global stall freezes all three stages while the output is blocked.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic [2:0]             rnd,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   z,
  output logic [7:0]             status,
  output logic [TAG_W-1:0]       out_tag
);
  localparam int EW = EXP_W + 2;
  localparam int PW = 2*MAN_W + 2;
  localparam logic [EW-1:0]    BIAS   = EW'((1 << (EXP_W-1)) - 1);
  localparam logic [EW-1:0]    EW_ONE = EW'(1);
  localparam logic [EXP_W-1:0] EMAX   = '1;
  localparam logic [EXP_W-1:0] EMAXM1 = EMAX - 1'b1;
  localparam logic [EW-1:0]    EMAX_W = {2'b00, EMAX};

  localparam logic [2:0] RM_NEAR = 3'd0, RM_ZERO = 3'd1, RM_PINF = 3'd2,
                         RM_NINF = 3'd3, RM_NUP  = 3'd4, RM_AWAY = 3'd5;
  localparam logic [1:0] SP_NONE = 2'd0, SP_ZERO = 2'd1, SP_INF = 2'd2, SP_NAN = 2'd3;

  typedef struct packed {
    logic             sign;
    logic [EW-1:0]    exp;
    logic [PW-1:0]    prod;
    logic [1:0]       sp;
    logic [2:0]       rnd;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EW-1:0]    exp;
    logic [MAN_W-1:0] mant;
    logic             grd;
    logic             stk;
    logic [1:0]       sp;
    logic [2:0]       rnd;
    logic [TAG_W-1:0] tag;
  } s2_t;

  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic [2:0]           vld_pipe_q;
  logic [EXP_W+MAN_W:0] z_d, z_q;
  logic [7:0]           st_d, st_q;
  logic [TAG_W-1:0]     tag_q;
  logic                 stall;

  assign stall     = vld_pipe_q[2] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = vld_pipe_q[2];
  assign z         = z_q;
  assign status    = st_q;
  assign out_tag   = tag_q;

  // S1: classify (subnormals count as zero), exponent sum, significand product
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  assign ea = a[MAN_W +: EXP_W];
  assign eb = b[MAN_W +: EXP_W];
  assign fa = a[MAN_W-1:0];
  assign fb = b[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == EMAX) && (fa == '0);
  assign b_inf  = (eb == EMAX) && (fb == '0);
  assign a_nan  = (ea == EMAX) && (fa != '0);
  assign b_nan  = (eb == EMAX) && (fb != '0);

  always_comb begin
    s1_d.sign = a[EXP_W+MAN_W] ^ b[EXP_W+MAN_W];
    s1_d.exp  = {2'b00, ea} + {2'b00, eb} - BIAS;
    s1_d.prod = PW'({1'b1, fa}) * PW'({1'b1, fb});
    s1_d.rnd  = rnd;
    s1_d.tag  = in_tag;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) s1_d.sp = SP_NAN;
    else if (a_inf || b_inf)                                      s1_d.sp = SP_INF;
    else if (a_zero || b_zero)                                    s1_d.sp = SP_ZERO;
    else                                                          s1_d.sp = SP_NONE;
  end

  // S2: product lies in [1,4); fold the shifted-out bit into sticky when >= 2
  logic              msb;
  logic [2*MAN_W-1:0] pn;
  assign msb = s1_q.prod[PW-1];
  assign pn  = msb ? {s1_q.prod[2*MAN_W:2], s1_q.prod[1] | s1_q.prod[0]}
                   : s1_q.prod[2*MAN_W-1:0];

  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.exp  = s1_q.exp + {{(EW-1){1'b0}}, msb};
    s2_d.mant = pn[2*MAN_W-1:MAN_W];
    s2_d.grd  = pn[MAN_W-1];
    s2_d.stk  = |pn[MAN_W-2:0];
    s2_d.sp   = s1_q.sp;
    s2_d.rnd  = s1_q.rnd;
    s2_d.tag  = s1_q.tag;
  end

  // S3: round, renormalise on carry-out, then apply overflow/underflow/specials
  logic             inc, inexact, dir_up, dir_dn, carry, unf, ovf;
  logic [MAN_W-1:0] mant_r;
  logic [EW-1:0]    exp_r;
  assign inexact = s2_q.grd | s2_q.stk;
  assign dir_up  = (s2_q.rnd == RM_PINF && !s2_q.sign) || (s2_q.rnd == RM_NINF &&  s2_q.sign);
  assign dir_dn  = (s2_q.rnd == RM_PINF &&  s2_q.sign) || (s2_q.rnd == RM_NINF && !s2_q.sign);

  always_comb begin
    case (s2_q.rnd)
      RM_ZERO: inc = 1'b0;
      RM_PINF: inc = ~s2_q.sign & inexact;
      RM_NINF: inc =  s2_q.sign & inexact;
      RM_NUP:  inc = s2_q.grd & (s2_q.stk | ~s2_q.sign);
      RM_AWAY: inc = inexact;
      default: inc = s2_q.grd & (s2_q.stk | s2_q.mant[0]);
    endcase
  end

  assign {carry, mant_r} = {1'b0, s2_q.mant} + {{MAN_W{1'b0}}, inc};
  assign exp_r = s2_q.exp + {{(EW-1){1'b0}}, carry};
  assign unf   = $signed(s2_q.exp) < $signed(EW_ONE);
  assign ovf   = $signed(exp_r) >= $signed(EMAX_W);

  always_comb begin
    z_d  = '0;
    st_d = '0;
    case (s2_q.sp)
      SP_NAN: begin
        z_d  = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
        st_d = 8'h04;
      end
      SP_INF: begin
        z_d  = {s2_q.sign, EMAX, {MAN_W{1'b0}}};
        st_d = 8'h02;
      end
      SP_ZERO: begin
        z_d  = {s2_q.sign, {(EXP_W+MAN_W){1'b0}}};
        st_d = 8'h01;
      end
      default: begin
        if (unf) begin
          if (s2_q.rnd == RM_AWAY || dir_up) begin
            z_d  = {s2_q.sign, EXP_W'(1), {MAN_W{1'b0}}};
            st_d = 8'h28;
          end else begin
            z_d  = {s2_q.sign, {(EXP_W+MAN_W){1'b0}}};
            st_d = 8'h29;
          end
        end else if (ovf) begin
          if (s2_q.rnd == RM_ZERO || dir_dn) begin
            z_d  = {s2_q.sign, EMAXM1, {MAN_W{1'b1}}};
            st_d = 8'h30;
          end else begin
            z_d  = {s2_q.sign, EMAX, {MAN_W{1'b0}}};
            st_d = 8'h32;
          end
        end else begin
          z_d  = {s2_q.sign, exp_r[EXP_W-1:0], mant_r};
          st_d = {2'b00, inexact, 5'b00000};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      z_q        <= '0;
      st_q       <= '0;
      tag_q      <= '0;
    end else if (!stall) begin
      vld_pipe_q <= {vld_pipe_q[1:0], in_valid};
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      if (vld_pipe_q[1]) begin
        z_q   <= z_d;
        st_q  <= st_d;
        tag_q <= s2_q.tag;
      end
    end
  end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: directed corner cases, backpressure, mid-flight reset,
// and a randomized stream scored against an exact-arithmetic reference model.
module tb_fp_mult_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, z;
  logic [2:0]  rnd;
  logic [3:0]  in_tag, out_tag;
  logic [7:0]  status;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] z;
    logic [7:0]  st;
    logic [3:0]  tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rnd(rnd), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .status(status), .out_tag(out_tag)
  );

  // Exact product rounded to 24 significant bits by comparing the remainder to one half.
  function automatic logic [39:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] rm);
    logic sg;
    int ex, ey, sh, e;
    logic xz, yz, xi, yi, xn, yn, up, exact, above, tie;
    logic [47:0] p, r, half;
    logic [24:0] m;
    sg = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    if (xn || yn || (xz && yi) || (xi && yz)) return {32'h7FC00000, 8'h04};
    if (xi || yi) return {sg, 8'hFF, 23'd0, 8'h02};
    if (xz || yz) return {sg, 31'd0, 8'h01};
    p     = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
    sh    = p[47] ? 24 : 23;
    m     = 25'(p >> sh);
    r     = p & ((48'd1 << sh) - 48'd1);
    half  = 48'd1 << (sh - 1);
    e     = ex + ey - 127 + sh - 23;
    exact = (r == 0);
    above = (r > half);
    tie   = (r == half);
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = !sg && !exact;
      3'd3:    up = sg && !exact;
      3'd4:    up = above || (tie && !sg);
      3'd5:    up = !exact;
      default: up = above || (tie && m[0]);
    endcase
    if (e < 1) begin
      if (rm == 3'd5 || (rm == 3'd2 && !sg) || (rm == 3'd3 && sg))
        return {sg, 8'd1, 23'd0, 8'h28};
      return {sg, 31'd0, 8'h29};
    end
    m = m + 25'(up);
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) begin
      if (rm == 3'd1 || (rm == 3'd2 && sg) || (rm == 3'd3 && !sg))
        return {sg, 8'hFE, 23'h7FFFFF, 8'h30};
      return {sg, 8'hFF, 23'd0, 8'h32};
    end
    return {sg, 8'(e), m[22:0], exact ? 8'h00 : 8'h20};
  endfunction

  function automatic logic [31:0] gen_op();
    int          k;
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    k = $urandom_range(0, 15);
    s = 1'($urandom);
    f = 23'($urandom);
    case (k)
      0:       begin e = 8'd0; f = '0; end
      1:       begin e = 8'hFF; f = '0; end
      2:       begin e = 8'hFF; if (f == 0) f = 23'd1; end
      3:       begin e = 8'd0; if (f == 0) f = 23'd1; end
      4:       e = 8'($urandom_range(230, 254));
      5:       e = 8'($urandom_range(1, 20));
      6, 7:    e = 8'($urandom_range(55, 75));
      8, 9:    begin e = 8'($urandom_range(100, 154)); f[11:0] = '0; end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {s, e, f};
  endfunction

  task automatic idle();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    rnd      = 3'd0;
    in_tag   = '0;
  endtask

  task automatic test_reset();
    int seen;
    rst       = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 32'h3FC00000;
    b         = 32'h40000000;
    rnd       = 3'd0;
    in_tag    = 4'd7;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (z !== 32'h0) begin n_err++; $display("FAIL reset_z got=%h want=00000000", z); end
    n_cmp++; if (status !== 8'h00) begin n_err++; $display("FAIL reset_status got=%h want=00", status); end
    n_cmp++; if (out_tag !== 4'h0) begin n_err++; $display("FAIL reset_tag got=%h want=0", out_tag); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL reset_no_output got=%0d want=0", seen); end
  endtask

  task automatic test_directed();
    logic [31:0] va[7] = '{32'h3FC00000, 32'h7F000000, 32'h7F000000, 32'h00800000,
                           32'h00800000, 32'h00000000, 32'hFF800000};
    logic [31:0] vb[7] = '{32'h40000000, 32'h7F000000, 32'h7F000000, 32'h3F000000,
                           32'h3F000000, 32'h7F800000, 32'h40000000};
    logic [2:0]  vr[7] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd2, 3'd0, 3'd0};
    logic [3:0]  vt[7] = '{4'd5, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
    logic [31:0] vz[7] = '{32'h40400000, 32'h7F800000, 32'h7F7FFFFF, 32'h00000000,
                           32'h00800000, 32'h7FC00000, 32'hFF800000};
    logic [7:0]  vs[7] = '{8'h00, 8'h32, 8'h30, 8'h29, 8'h28, 8'h04, 8'h02};
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      a        = va[i];
      b        = vb[i];
      rnd      = vr[i];
      in_tag   = vt[i];
      @(posedge clk); #1;
      idle();
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      n_cmp++; if (lat != 3) begin n_err++; $display("FAIL dir%0d_latency got=%0d want=3", i, lat); end
      n_cmp++; if (z !== vz[i]) begin n_err++; $display("FAIL dir%0d_z got=%h want=%h", i, z, vz[i]); end
      n_cmp++; if (status !== vs[i]) begin n_err++; $display("FAIL dir%0d_status got=%h want=%h", i, status, vs[i]); end
      n_cmp++; if (out_tag !== vt[i]) begin n_err++; $display("FAIL dir%0d_tag got=%h want=%h", i, out_tag, vt[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int nxt, got, held, last;
    nxt  = 1;
    got  = 0;
    held = -1;
    last = -1;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(posedge clk); #1;
      out_ready = (c >= 6);
      in_valid  = (nxt <= 6);
      a         = 32'h3FC00000;
      b         = 32'h40000000;
      rnd       = 3'd0;
      in_tag    = 4'(nxt);
      @(negedge clk);
      if (!in_ready && held < 0) held = nxt - 1;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_tag !== 4'(got + 1)) begin n_err++; $display("FAIL b2b_tag got=%0d want=%0d", out_tag, got + 1); end
        n_cmp++; if (z !== 32'h40400000) begin n_err++; $display("FAIL b2b_z got=%h want=40400000", z); end
        if (last >= 0) begin
          n_cmp++; if (c != last + 1) begin n_err++; $display("FAIL b2b_gap cycle=%0d want=%0d", c, last + 1); end
        end
        last = c;
        got++;
      end
      if (in_valid && in_ready) nxt++;
    end
    @(posedge clk); #1;
    idle();
    n_cmp++; if (held != 3) begin n_err++; $display("FAIL b2b_held got=%0d want=3", held); end
    n_cmp++; if (got != 6) begin n_err++; $display("FAIL b2b_count got=%0d want=6", got); end
  endtask

  task automatic test_reset_midflight();
    int seen, lat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    a        = 32'h3FC00000;
    b        = 32'h40000000;
    in_tag   = 4'd9;
    @(posedge clk); #1;
    in_tag   = 4'd10;
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_out_valid got=%b want=0", out_valid); end
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL mid_rst_ghost got=%0d want=0", seen); end
    in_valid = 1'b1;
    a        = 32'h40400000;
    b        = 32'h40400000;
    in_tag   = 4'd11;
    @(posedge clk); #1;
    idle();
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_cmp++; if (lat != 3) begin n_err++; $display("FAIL mid_rst_latency got=%0d want=3", lat); end
    n_cmp++; if (z !== 32'h41100000) begin n_err++; $display("FAIL mid_rst_z got=%h want=41100000", z); end
    n_cmp++; if (out_tag !== 4'd11) begin n_err++; $display("FAIL mid_rst_tag got=%h want=b", out_tag); end
  endtask

  task automatic test_random();
    exp_t        e;
    logic [39:0] r;
    for (int c = 0; c < 440; c++) begin
      @(posedge clk); #1;
      if (c < 400) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        a         = gen_op();
        b         = gen_op();
        rnd       = 3'($urandom_range(0, 5));
        in_tag    = 4'($urandom);
        out_ready = ($urandom_range(0, 9) < 7);
      end else begin
        idle();
        out_ready = 1'b1;
      end
      @(negedge clk);
      n_cmp++; if (in_ready !== !(out_valid && !out_ready)) begin
        n_err++; $display("FAIL rnd_in_ready c=%0d got=%b ov=%b or=%b", c, in_ready, out_valid, out_ready);
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++; $display("FAIL rnd_spurious c=%0d z=%h", c, z);
        end else begin
          e = sb.pop_front();
          if (z !== e.z || status !== e.st || out_tag !== e.tag) begin
            n_err++;
            $display("FAIL rnd_result c=%0d got z=%h st=%h tag=%h want z=%h st=%h tag=%h",
                     c, z, status, out_tag, e.z, e.st, e.tag);
          end
        end
      end
      if (in_valid && in_ready) begin
        r     = ref_mul(a, b, rnd);
        e.z   = r[39:8];
        e.st  = r[7:0];
        e.tag = in_tag;
        sb.push_back(e);
      end
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL rnd_drain left=%0d want=0", sb.size()); end
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    idle();
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
